// File: rtl/sbox_key_add_pkg.sv
// Shared constants for the iterated S-box/key-add engine: nibble width, S-box table, FSM states.
package sbox_key_add_pkg;

  localparam int unsigned NIBBLE_W = 4;

  // 4-bit bijective S-box with SBOX(0) = 0
  localparam logic [3:0] SBOX_TABLE [16] = '{
    4'h0, 4'hE, 4'h4, 4'hD, 4'h1, 4'h2, 4'hF, 4'hB,
    4'h8, 4'h3, 4'hA, 4'h6, 4'hC, 4'h5, 4'h9, 4'h7
  };

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/sbox_key_add_iter_sbox4.sv
// Combinational 4-bit S-box lookup.
module sbox4
  import sbox_key_add_pkg::*;
(
  input  logic [NIBBLE_W-1:0] x,
  output logic [NIBBLE_W-1:0] y_c
);

  assign y_c = SBOX_TABLE[x];

endmodule

// File: rtl/sbox_key_add_iter.sv
// Iterated S-box/key-add engine with optional duplicated datapath for fault detection.
module sbox_key_add_iter
  import sbox_key_add_pkg::*;
#(
  parameter int unsigned NIBBLES   = 4,
  parameter int unsigned ROUNDS    = 4,
  parameter int unsigned REDUNDANT = 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          io_in_valid,
  output logic                          io_in_ready,
  input  logic [NIBBLES*NIBBLE_W-1:0]   io_in_state,
  input  logic [NIBBLES*NIBBLE_W-1:0]   io_in_key,
  input  logic                          io_flt_en,
  input  logic [3:0]                    io_flt_round,
  input  logic [NIBBLES*NIBBLE_W-1:0]   io_flt_mask,
  output logic                          io_out_valid,
  input  logic                          io_out_ready,
  output logic [NIBBLES*NIBBLE_W-1:0]   io_out_data,
  output logic                          io_out_fault
);

  localparam int unsigned W     = NIBBLES * NIBBLE_W;
  localparam int unsigned CNT_W = 4;

  state_e           state_q, state_d;
  logic [W-1:0]     pri_q, pri_d, key_q, key_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ready_d, valid_d, fault_d;
  logic [W-1:0]     data_d;

  logic [W-1:0]     pri_sb, pri_rnd, key_rot;
  logic             flt_hit, mism_c, load_c, step_c;

  for (genvar i = 0; i < NIBBLES; i++) begin : g_pri
    sbox4 u_sbox (.x(pri_q[i*NIBBLE_W +: NIBBLE_W]), .y_c(pri_sb[i*NIBBLE_W +: NIBBLE_W]));
  end

  // Fault mask only touches the primary path; cnt_q < ROUNDS in RUN so out-of-range rounds never hit
  assign flt_hit = io_flt_en && (io_flt_round == cnt_q);
  assign pri_rnd = pri_sb ^ key_q ^ (flt_hit ? io_flt_mask : W'(0));
  assign key_rot = (key_q << NIBBLE_W) | (key_q >> (W - NIBBLE_W));

  if (REDUNDANT != 0) begin : g_red
    logic [W-1:0] red_q, red_sb, red_rnd;

    for (genvar i = 0; i < NIBBLES; i++) begin : g_sb
      sbox4 u_sbox (.x(red_q[i*NIBBLE_W +: NIBBLE_W]), .y_c(red_sb[i*NIBBLE_W +: NIBBLE_W]));
    end

    assign red_rnd = red_sb ^ key_q;
    assign mism_c  = (pri_rnd != red_rnd);

    always_ff @(posedge clock or posedge reset) begin
      if (reset)       red_q <= '0;
      else if (load_c) red_q <= io_in_state;
      else if (step_c) red_q <= red_rnd;
    end
  end else begin : g_nored
    assign mism_c = 1'b0;
  end

  // State and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      pri_q        <= '0;
      key_q        <= '0;
      cnt_q        <= '0;
      io_in_ready  <= 1'b1;
      io_out_valid <= 1'b0;
      io_out_data  <= '0;
      io_out_fault <= 1'b0;
    end else begin
      state_q      <= state_d;
      pri_q        <= pri_d;
      key_q        <= key_d;
      cnt_q        <= cnt_d;
      io_in_ready  <= ready_d;
      io_out_valid <= valid_d;
      io_out_data  <= data_d;
      io_out_fault <= fault_d;
    end
  end

  // Next-state and output logic; results are latched on the final round
  always_comb begin
    state_d = state_q;
    pri_d   = pri_q;
    key_d   = key_q;
    cnt_d   = cnt_q;
    ready_d = io_in_ready;
    valid_d = io_out_valid;
    data_d  = io_out_data;
    fault_d = io_out_fault;
    load_c  = 1'b0;
    step_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (io_in_valid) begin
          load_c  = 1'b1;
          state_d = ST_RUN;
          pri_d   = io_in_state;
          key_d   = io_in_key;
          cnt_d   = '0;
          ready_d = 1'b0;
        end
      end
      ST_RUN: begin
        step_c = 1'b1;
        pri_d  = pri_rnd;
        key_d  = key_rot;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(ROUNDS - 1)) begin
          state_d = ST_DONE;
          valid_d = 1'b1;
          fault_d = mism_c;
          data_d  = mism_c ? W'(0) : pri_rnd;
        end
      end
      ST_DONE: begin
        if (io_out_ready) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
          ready_d = 1'b1;
          data_d  = '0;
          fault_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_sbox_key_add_iter.sv
// Bench for sbox_key_add_iter: three configurations driven against a behavioural round model.
module tb_sbox_key_add_iter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] st = '0, key = '0, fm = '0;
  logic        fe = 1'b0;
  logic [3:0]  fr = '0;
  logic [2:0]  iv = '0, orr = '0;
  logic [2:0]  ir, ov, of;
  logic [15:0] od [3];

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0] tbl [16] = '{4'h0, 4'hE, 4'h4, 4'hD, 4'h1, 4'h2, 4'hF, 4'hB,
                           4'h8, 4'h3, 4'hA, 4'h6, 4'hC, 4'h5, 4'h9, 4'h7};

  always #5 clock = ~clock;

  // d0: 4 rounds redundant, d1: 1 round redundant, d2: 4 rounds single path
  sbox_key_add_iter #(.NIBBLES(4), .ROUNDS(4), .REDUNDANT(1)) u_main (
    .clock(clock), .reset(reset), .io_in_valid(iv[0]), .io_in_ready(ir[0]),
    .io_in_state(st), .io_in_key(key), .io_flt_en(fe), .io_flt_round(fr), .io_flt_mask(fm),
    .io_out_valid(ov[0]), .io_out_ready(orr[0]), .io_out_data(od[0]), .io_out_fault(of[0]));

  sbox_key_add_iter #(.NIBBLES(4), .ROUNDS(1), .REDUNDANT(1)) u_r1 (
    .clock(clock), .reset(reset), .io_in_valid(iv[1]), .io_in_ready(ir[1]),
    .io_in_state(st), .io_in_key(key), .io_flt_en(fe), .io_flt_round(fr), .io_flt_mask(fm),
    .io_out_valid(ov[1]), .io_out_ready(orr[1]), .io_out_data(od[1]), .io_out_fault(of[1]));

  sbox_key_add_iter #(.NIBBLES(4), .ROUNDS(4), .REDUNDANT(0)) u_nr (
    .clock(clock), .reset(reset), .io_in_valid(iv[2]), .io_in_ready(ir[2]),
    .io_in_state(st), .io_in_key(key), .io_flt_en(fe), .io_flt_round(fr), .io_flt_mask(fm),
    .io_out_valid(ov[2]), .io_out_ready(orr[2]), .io_out_data(od[2]), .io_out_fault(of[2]));

  function automatic logic [15:0] model(input logic [15:0] s, input logic [15:0] k, input int rounds,
                                        input bit e, input int r, input logic [15:0] m);
    logic [15:0] ns;
    for (int rr = 0; rr < rounds; rr++) begin
      for (int i = 0; i < 4; i++) ns[i*4 +: 4] = tbl[s[i*4 +: 4]] ^ k[i*4 +: 4];
      if (e && r == rr) ns = ns ^ m;
      s = ns;
      k = {k[11:0], k[15:12]};
    end
    return s;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one job on DUT d from a negedge; returns at a negedge with the DUT back in IDLE
  task automatic do_job(input int d, input logic [15:0] s, input logic [15:0] k, input bit e,
                        input logic [3:0] r, input logic [15:0] m, input int lat, input int hold,
                        output logic [15:0] data, output logic f);
    int n;
    st = s; key = k; fe = e; fr = r; fm = m; iv[d] = 1'b1; orr[d] = 1'b0;
    check($sformatf("accept_ready_d%0d", d), 32'(ir[d]), 32'd1);
    @(negedge clock);
    st = 16'($urandom); key = 16'($urandom);
    n = 1;
    while (!ov[d] && n < 40) begin
      @(negedge clock);
      n++;
    end
    iv[d] = 1'b0;
    check($sformatf("latency_d%0d", d), 32'(n), 32'(lat));
    data = od[d];
    f = of[d];
    for (int h = 0; h < hold; h++) begin
      check("hold_in_ready", 32'(ir[d]), 32'd0);
      @(negedge clock);
      check("hold_valid", 32'(ov[d]), 32'd1);
      check("hold_data", 32'(od[d]), 32'(data));
    end
    orr[d] = 1'b1;
    @(negedge clock);
    orr[d] = 1'b0;
    check($sformatf("post_valid_d%0d", d), 32'(ov[d]), 32'd0);
    check($sformatf("post_ready_d%0d", d), 32'(ir[d]), 32'd1);
  endtask

  initial begin
    logic [15:0] data, s, k, gold, q [$];
    logic        f, acc, seen;
    int          last, n_res;

    repeat (2) @(negedge clock);
    check("rst_in_ready", 32'(ir[0]), 32'd1);
    check("rst_out_valid", 32'(ov[0]), 32'd0);
    check("rst_out_data", 32'(od[0]), 32'd0);
    check("rst_out_fault", 32'(of[0]), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // Single round, zero state: result is the key
    do_job(1, 16'h0000, 16'hA5C3, 1'b0, 4'd0, 16'h0, 2, 0, data, f);
    check("r1_data", 32'(data), 32'h0000A5C3);
    check("r1_fault", 32'(f), 32'd0);

    // Zero state/key with back-pressure on the result
    do_job(0, 16'h0000, 16'h0000, 1'b0, 4'd0, 16'h0, 5, 3, data, f);
    check("zero_data", 32'(data), 32'd0);
    check("zero_fault", 32'(f), 32'd0);

    for (int j = 0; j < 4; j++) begin
      s = 16'($urandom); k = 16'($urandom);
      do_job(0, s, k, 1'b0, 4'd0, 16'h0, 5, 0, data, f);
      check("rand_data", 32'(data), 32'(model(s, k, 4, 1'b0, 0, 16'h0)));
      check("rand_fault", 32'(f), 32'd0);
      do_job(1, s, k, 1'b0, 4'd0, 16'h0, 2, 0, data, f);
      check("rand_r1_data", 32'(data), 32'(model(s, k, 1, 1'b0, 0, 16'h0)));
    end

    // Fault round beyond the last round has no effect
    s = 16'($urandom); k = 16'($urandom);
    do_job(0, s, k, 1'b1, 4'($urandom_range(4, 15)), 16'hFFFF, 5, 0, data, f);
    check("oor_data", 32'(data), 32'(model(s, k, 4, 1'b0, 0, 16'h0)));
    check("oor_fault", 32'(f), 32'd0);

    // Injected fault: detected and suppressed with redundancy, silent without
    s = 16'($urandom); k = 16'($urandom);
    do_job(0, s, k, 1'b1, 4'd2, 16'h0001, 5, 0, data, f);
    check("flt_fault", 32'(f), 32'd1);
    check("flt_data", 32'(data), 32'd0);
    do_job(2, s, k, 1'b1, 4'd2, 16'h0001, 5, 0, data, f);
    gold = model(s, k, 4, 1'b0, 0, 16'h0);
    check("nr_fault", 32'(f), 32'd0);
    check("nr_data", 32'(data), 32'(model(s, k, 4, 1'b1, 2, 16'h0001)));
    check("nr_differs", 32'(data !== gold), 32'd1);
    fe = 1'b0;

    // Reset during round 2 aborts the job
    st = 16'($urandom); key = 16'($urandom); iv[0] = 1'b1;
    @(negedge clock);
    iv[0] = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    #1;
    check("abort_in_ready", 32'(ir[0]), 32'd1);
    check("abort_out_valid", 32'(ov[0]), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      seen = seen | ov[0];
    end
    check("abort_no_valid", 32'(seen), 32'd0);
    s = 16'($urandom); k = 16'($urandom);
    do_job(0, s, k, 1'b0, 4'd0, 16'h0, 5, 0, data, f);
    check("after_abort_data", 32'(data), 32'(model(s, k, 4, 1'b0, 0, 16'h0)));

    // Back-to-back jobs with the consumer always ready
    iv[0] = 1'b1; orr[0] = 1'b1; last = -1; n_res = 0;
    for (int cyc = 0; cyc < 70; cyc++) begin
      if (ov[0]) begin
        n_res++;
        gold = (q.size() > 0) ? q.pop_front() : 16'hxxxx;
        check("b2b_data", 32'(od[0]), 32'(gold));
        check("b2b_fault", 32'(of[0]), 32'd0);
      end
      acc = ir[0];
      if (acc) begin
        q.push_back(model(st, key, 4, 1'b0, 0, 16'h0));
        if (last >= 0) check("b2b_spacing", 32'(cyc - last), 32'd6);
        last = cyc;
      end
      @(negedge clock);
      if (acc) begin
        st = 16'($urandom); key = 16'($urandom);
      end
    end
    iv[0] = 1'b0; orr[0] = 1'b0;
    check("b2b_results", 32'(n_res), 32'd11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sbox_key_add_iter.md
SBOX_KEY_ADD_ITER -- requirements
Module: sbox_key_add_iter

Interface
REQ-001 SHALL have parameter NIBBLES, default 4: number of parallel 4-bit S-box/key-add lanes (1..16).
REQ-002 SHALL have parameter ROUNDS, default 4: number of iterated S-box/key-add rounds per job (1..15).
REQ-003 SHALL have parameter REDUNDANT, default 1: 1 = duplicated datapath with compare, 0 = single datapath.
REQ-004 SHALL use one clock and an asynchronous, active-high reset: ports `clock` and `reset`.
REQ-005 clock  input  1  rising-edge clock.
REQ-006 reset  input  1  asynchronous active-high reset.
REQ-007 io_in_valid  input  1  job request.
REQ-008 io_in_ready  output  1  block can accept a job.
REQ-009 io_in_state  input  4*NIBBLES  initial state; nibble i = bits [4i+3:4i].
REQ-010 io_in_key  input  4*NIBBLES  round key.
REQ-011 io_flt_en  input  1  fault-injection enable (test only).
REQ-012 io_flt_round  input  4  round index at which the fault is injected.
REQ-013 io_flt_mask  input  4*NIBBLES  XOR mask applied to the primary state.
REQ-014 io_out_valid  output  1  result available.
REQ-015 io_out_ready  input  1  consumer accepts the result.
REQ-016 io_out_data  output  4*NIBBLES  result, or all-zero when suppressed.
REQ-017 io_out_fault  output  1  redundant-path mismatch detected for this job.

Function
REQ-018 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE.
REQ-019 io_in_ready SHALL be 1 only in IDLE; a job is accepted when io_in_valid & io_in_ready.
REQ-020 On accept: capture the state into the primary and redundant state registers, capture the key, set the round counter to 0, and go to RUN.
REQ-021 Each RUN cycle: every nibble i SHALL become SBOX(s_i) XOR k_i; the key register SHALL rotate left by 4 bits; the round counter SHALL increment.
REQ-022 If io_flt_en = 1 and io_flt_round equals the round counter: the primary next-state SHALL additionally be XORed with io_flt_mask; the redundant next-state SHALL be unaffected.
REQ-023 After the round with counter = ROUNDS-1, the FSM SHALL go to DONE; latency from accept to io_out_valid = ROUNDS+1 cycles.
REQ-024 io_out_valid SHALL be 1 only in DONE; the FSM SHALL stay in DONE and hold outputs stable until io_out_ready = 1, then go to IDLE.
REQ-025 With REDUNDANT = 1: io_out_fault = 1 when the primary and redundant states differ in DONE; io_out_data SHALL then be all-zero (suppression); otherwise io_out_data = the primary state.
REQ-026 With REDUNDANT = 0: no redundant registers; io_out_fault tied to 0; io_out_data = the primary state.
REQ-027 io_flt_round values >= ROUNDS SHALL have no effect.
REQ-028 io_in_valid during RUN or DONE SHALL be ignored, with no queuing.
REQ-029 io_out_ready asserted outside DONE SHALL be ignored.
REQ-030 Input changes after accept SHALL not affect the running job.

Reset
REQ-031 On reset: FSM = IDLE, all state/key registers and the round counter = 0, io_in_ready = 1, io_out_valid = 0, io_out_data = 0, io_out_fault = 0.
REQ-032 Reset mid-RUN or in DONE SHALL abort the job immediately, with no output produced.

Structure
REQ-033 Package sbox_key_add_pkg SHALL hold the 16x4 SBOX_TABLE constant (SBOX(0) = 0), the FSM state enum, and the nibble width constant 4.
REQ-034 SHALL instantiate sub-module sbox4 (combinational 4-bit lookup), NIBBLES times per datapath.

Verification
REQ-035 NIBBLES=4, ROUNDS=1, state 0x0000, key 0xA5C3 -> io_out_data = 0xA5C3, io_out_fault = 0, io_out_valid 2 cycles after accept.
REQ-036 ROUNDS=4, state 0x0000, key 0x0000 -> io_out_data = 0x0000 after 5 cycles; io_out_ready held 0 for 3 cycles -> output held stable and io_in_ready = 0.
REQ-037 ROUNDS=4, io_flt_en=1, io_flt_round=2, io_flt_mask=0x0001, random state/key -> io_out_fault = 1 and io_out_data = 0x0000.
REQ-038 REDUNDANT=0, same fault stimulus -> io_out_fault = 0 and io_out_data differs from the golden model.
REQ-039 Assert reset in RUN round 2 -> next cycle: IDLE, io_in_ready = 1, io_out_valid never asserted; a new job then completes correctly.
REQ-040 Back-to-back jobs with io_out_ready = 1 constantly -> one job per ROUNDS+2 cycles; all results match a golden model using SBOX_TABLE.
